// File: rtl/alu_ctrl.sv
// alu_ctrl: board front end for a small registered ALU.
// Buttons are synchronised, debounced and edge-detected into load pulses that
// capture operand A, operand B and the opcode from a shared switch bus. A
// three-state FSM evaluates the ALU once per operand change and holds the
// registered result and flags with a valid indication.
module alu_ctrl #(
  parameter int BITS_DATA       = 8,
  parameter int BITS_OP         = 6,
  parameter int BUTTONS         = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [BITS_DATA-1:0] i_switches,
  input  logic [BUTTONS-1:0]   i_buttons,
  output logic [BITS_DATA-1:0] o_result,
  output logic                 o_zero,
  output logic                 o_carry,
  output logic                 o_overflow,
  output logic                 o_invalid_op,
  output logic                 o_valid,
  output logic                 o_busy
);

  localparam int CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int OP_DEC_W = 6;
  localparam logic [BITS_DATA:0] SHIFT_LIMIT = (BITS_DATA + 1)'(BITS_DATA);

  localparam logic [OP_DEC_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_DEC_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_DEC_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_DEC_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_DEC_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_DEC_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_DEC_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_DEC_W-1:0] OP_SRL = 6'b000010;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // synchronisers
  logic [BUTTONS-1:0]   btn_meta_r, btn_sync_r;
  logic [BITS_DATA-1:0] sw_meta_r, sw_sync_r;

  // debounce / edge detect
  logic [BUTTONS-1:0]   deb_lvl_s, arm_s, deb_prev_r, pulse_s;

  // operand storage
  logic [BITS_DATA-1:0] a_r, b_r;
  logic [BITS_OP-1:0]   op_r;
  logic [BUTTONS-1:0]   mask_r, mask_next_s;
  logic                 all_loaded_s, any_pulse_s;

  // FSM
  state_t               state_r, state_next_s;
  logic                 busy_r, valid_r;

  // ALU
  logic [BITS_DATA-1:0] alu_res_s;
  logic [BITS_DATA:0]   sum_s;
  logic                 alu_carry_s, alu_ovf_s, alu_inv_s;
  logic                 op_hi_zero_s, shift_big_s;

  // registered outputs
  logic [BITS_DATA-1:0] result_r;
  logic                 zero_r, carry_r, ovf_r, inv_r;

  // Two-flop synchronisers for the asynchronous buttons and switch bus
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      btn_meta_r <= '0;
      btn_sync_r <= '0;
      sw_meta_r  <= '0;
      sw_sync_r  <= '0;
    end else begin
      btn_meta_r <= i_buttons;
      btn_sync_r <= btn_meta_r;
      sw_meta_r  <= i_switches;
      sw_sync_r  <= sw_meta_r;
    end
  end

  for (genvar k = 0; k < BUTTONS; k++) begin : g_btn
    logic [CNT_W-1:0] cnt_r;
    logic             deb_r;
    logic             arm_r;

    // Debounce: accept a new level after DEBOUNCE_CYCLES differing samples.
    // After reset a button is only armed once it has been seen stably
    // released, so a press held through reset never produces a load.
    always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
        cnt_r <= '0;
        deb_r <= 1'b0;
        arm_r <= 1'b0;
      end else if (btn_sync_r[k] != deb_r) begin
        if (cnt_r == CNT_LAST) begin
          deb_r <= btn_sync_r[k];
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else if (!arm_r && !deb_r) begin
        if (cnt_r == CNT_LAST) begin
          arm_r <= 1'b1;
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= '0;
      end
    end

    assign deb_lvl_s[k] = deb_r;
    assign arm_s[k]     = arm_r;
  end

  // Previous debounced level for rising-edge detection
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      deb_prev_r <= '0;
    end else begin
      deb_prev_r <= deb_lvl_s;
    end
  end

  assign pulse_s      = deb_lvl_s & ~deb_prev_r & arm_s;
  assign any_pulse_s  = |pulse_s;
  assign mask_next_s  = mask_r | pulse_s;
  assign all_loaded_s = &mask_next_s;

  // Operand capture on load pulses; simultaneous pulses share the value
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      mask_r <= '0;
    end else begin
      if (pulse_s[0]) begin
        a_r <= sw_sync_r;
      end
      if (pulse_s[1]) begin
        b_r <= sw_sync_r;
      end
      if (pulse_s[2]) begin
        op_r <= sw_sync_r[BITS_OP-1:0];
      end
      mask_r <= mask_next_s;
    end
  end

  // Next-state logic: evaluate once all operands are present and again on
  // every later load, including one arriving mid-evaluation
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_WAIT: begin
        if (all_loaded_s) begin
          state_next_s = S_EXEC;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_EXEC: begin
        if (any_pulse_s) begin
          state_next_s = S_EXEC;
        end else begin
          state_next_s = S_HOLD;
        end
      end
      S_HOLD: begin
        if (any_pulse_s) begin
          state_next_s = S_EXEC;
        end else begin
          state_next_s = S_HOLD;
        end
      end
      default: begin
        state_next_s = S_WAIT;
      end
    endcase
  end

  // State register with busy/valid registered from the next state
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= S_WAIT;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == S_EXEC);
      valid_r <= (state_next_s == S_HOLD);
    end
  end

  assign op_hi_zero_s = ((op_r >> OP_DEC_W) == '0);
  assign shift_big_s  = ({1'b0, b_r} >= SHIFT_LIMIT);

  // Combinational ALU over the captured operands
  always_comb begin
    alu_res_s   = '0;
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    alu_inv_s   = 1'b0;
    sum_s       = '0;
    if (op_hi_zero_s) begin
      case (op_r[OP_DEC_W-1:0])
        OP_ADD: begin
          sum_s       = {1'b0, a_r} + {1'b0, b_r};
          alu_res_s   = sum_s[BITS_DATA-1:0];
          alu_carry_s = sum_s[BITS_DATA];
          alu_ovf_s   = (a_r[BITS_DATA-1] == b_r[BITS_DATA-1]) &&
                        (sum_s[BITS_DATA-1] != a_r[BITS_DATA-1]);
        end
        OP_SUB: begin
          // the extra MSB of the widened difference is the borrow (A < B)
          sum_s       = {1'b0, a_r} - {1'b0, b_r};
          alu_res_s   = sum_s[BITS_DATA-1:0];
          alu_carry_s = sum_s[BITS_DATA];
          alu_ovf_s   = (a_r[BITS_DATA-1] != b_r[BITS_DATA-1]) &&
                        (sum_s[BITS_DATA-1] != a_r[BITS_DATA-1]);
        end
        OP_AND: alu_res_s = a_r & b_r;
        OP_OR:  alu_res_s = a_r | b_r;
        OP_XOR: alu_res_s = a_r ^ b_r;
        OP_NOR: alu_res_s = ~(a_r | b_r);
        OP_SRA: begin
          if (shift_big_s) begin
            alu_res_s = {BITS_DATA{a_r[BITS_DATA-1]}};
          end else begin
            alu_res_s = $signed(a_r) >>> b_r;
          end
        end
        OP_SRL: begin
          if (shift_big_s) begin
            alu_res_s = '0;
          end else begin
            alu_res_s = a_r >> b_r;
          end
        end
        default: alu_inv_s = 1'b1;
      endcase
    end else begin
      alu_inv_s = 1'b1;
    end
  end

  // Result and flags are captured only on the final evaluation cycle
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      result_r <= '0;
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      inv_r    <= 1'b0;
    end else if ((state_r == S_EXEC) && !any_pulse_s) begin
      result_r <= alu_res_s;
      zero_r   <= !alu_inv_s && (alu_res_s == '0);
      carry_r  <= alu_carry_s;
      ovf_r    <= alu_ovf_s;
      inv_r    <= alu_inv_s;
    end else begin
      result_r <= result_r;
      zero_r   <= zero_r;
      carry_r  <= carry_r;
      ovf_r    <= ovf_r;
      inv_r    <= inv_r;
    end
  end

  assign o_result     = result_r;
  assign o_zero       = zero_r;
  assign o_carry      = carry_r;
  assign o_overflow   = ovf_r;
  assign o_invalid_op = inv_r;
  assign o_valid      = valid_r;
  assign o_busy       = busy_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl (8-bit data, debounce of 4 samples).
// A transaction-level model tracks loaded operands and computes the expected
// outputs arithmetically; a negedge process compares every cycle.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_switches;
  logic [2:0] i_buttons;
  logic [7:0] o_result;
  logic       o_zero, o_carry, o_overflow, o_invalid_op, o_valid, o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;

  typedef struct {
    int         edge_n;
    logic [2:0] mask;
    logic [7:0] val;
  } ld_t;
  ld_t q[$];

  // model state
  logic [7:0] m_a, m_b;
  logic [5:0] m_op;
  logic [2:0] m_mask;
  int         last_load;
  logic [7:0] e_res;
  logic       e_zero, e_carry, e_ovf, e_inv, e_valid, e_busy;

  alu_ctrl #(
    .BITS_DATA(8), .BITS_OP(6), .BUTTONS(3), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_switches(i_switches), .i_buttons(i_buttons),
    .o_result(o_result), .o_zero(o_zero), .o_carry(o_carry),
    .o_overflow(o_overflow), .o_invalid_op(o_invalid_op),
    .o_valid(o_valid), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // posedge counter used to time scheduled loads
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // {invalid, overflow, carry, zero, result}
  function automatic logic [11:0] model_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
    int ia, ib, sa, sb, r;
    logic c, v, inv;
    ia = a; ib = b;
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    c = 1'b0; v = 1'b0; inv = 1'b0; r = 0;
    case (op)
      6'h20: begin r = ia + ib; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      6'h22: begin r = ia - ib; c = (ia < ib); v = (sa - sb > 127) || (sa - sb < -128); end
      6'h24: r = ia & ib;
      6'h25: r = ia | ib;
      6'h26: r = ia ^ ib;
      6'h27: r = ~(ia | ib);
      6'h03: r = (ib >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> ib);
      6'h02: r = (ib >= 8) ? 0 : (ia >> ib);
      default: begin inv = 1'b1; r = 0; end
    endcase
    r = r & 255;
    return {inv, v, c, (!inv && r == 0), r[7:0]};
  endfunction

  // Model update and per-cycle comparison
  initial begin
    forever begin
      @(negedge clk);
      if (i_reset) begin
        q.delete();
        m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_mask = 3'b000;
        last_load = -10;
        e_res = 8'h00; e_zero = 1'b0; e_carry = 1'b0; e_ovf = 1'b0; e_inv = 1'b0;
        e_valid = 1'b0; e_busy = 1'b0;
      end else begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].edge_n == cyc) begin
            if (q[i].mask[0]) m_a = q[i].val;
            if (q[i].mask[1]) m_b = q[i].val;
            if (q[i].mask[2]) m_op = q[i].val[5:0];
            m_mask = m_mask | q[i].mask;
            last_load = cyc;
            q.delete(i);
          end
        end
        if (m_mask == 3'b111) begin
          if (last_load == cyc) begin
            e_busy = 1'b1; e_valid = 1'b0;
          end else begin
            {e_inv, e_ovf, e_carry, e_zero, e_res} = model_alu(m_a, m_b, m_op);
            e_busy = 1'b0; e_valid = 1'b1;
          end
        end else begin
          e_busy = 1'b0; e_valid = 1'b0;
        end
      end
      if (o_busy) busy_cnt++;
      chk("result", o_result, e_res);
      chk("zero", o_zero, e_zero);
      chk("carry", o_carry, e_carry);
      chk("overflow", o_overflow, e_ovf);
      chk("invalid_op", o_invalid_op, e_inv);
      chk("valid", o_valid, e_valid);
      chk("busy", o_busy, e_busy);
    end
  end

  // Clean press: switches settle, button held `hold` cycles, then a quiet gap.
  // The load takes effect 7 edges after the press is applied (2 sync + 4
  // debounce samples + pulse cycle).
  task automatic press(input logic [2:0] which, input logic [7:0] v, input int hold);
    ld_t e;
    @(posedge clk); #1;
    i_switches = v;
    repeat (4) @(posedge clk);
    #1;
    i_buttons = i_buttons | which;
    e.edge_n = cyc + 7; e.mask = which; e.val = v;
    q.push_back(e);
    repeat (hold) @(posedge clk);
    #1;
    i_buttons = i_buttons & ~which;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    press(3'b001, a, 20);
    press(3'b010, b, 20);
    press(3'b100, op, 20);
  endtask

  initial begin
    int b0, h, l, el, which, hold;
    logic [7:0] v;
    logic [7:0] ops [8];
    ld_t e;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    i_reset = 1'b1; i_buttons = 3'b000; i_switches = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_result", o_result, 8'h00);
    chk("reset_busy", o_busy, 1'b0);
    i_reset = 1'b0;
    repeat (20) @(posedge clk);

    // 1: ADD with signed overflow
    load3(8'h7F, 8'h01, 8'h20);
    chk("t1_result", o_result, 8'h80);
    chk("t1_ovf", o_overflow, 1'b1);
    chk("t1_carry", o_carry, 1'b0);
    chk("t1_zero", o_zero, 1'b0);
    chk("t1_valid", o_valid, 1'b1);

    // 2: SUB equal operands, then borrow
    load3(8'h05, 8'h05, 8'h22);
    chk("t2_result", o_result, 8'h00);
    chk("t2_zero", o_zero, 1'b1);
    chk("t2_carry", o_carry, 1'b0);
    b0 = busy_cnt;
    press(3'b001, 8'h00, 20);
    chk("t2_busy_a", busy_cnt - b0, 1);
    chk("t2_result_a", o_result, 8'hFB);
    b0 = busy_cnt;
    press(3'b010, 8'h01, 20);
    chk("t2_busy_b", busy_cnt - b0, 1);
    chk("t2_result_b", o_result, 8'hFF);
    chk("t2_carry_b", o_carry, 1'b1);
    chk("t2_ovf_b", o_overflow, 1'b0);

    // 3: bouncing button0 never loads; a long press loads once
    b0 = busy_cnt;
    @(posedge clk); #1;
    i_switches = 8'h55;
    el = 0;
    while (el < 50) begin
      h = $urandom_range(1, 3);
      l = $urandom_range(1, 3);
      i_buttons[0] = 1'b1;
      repeat (h) @(posedge clk);
      #1;
      i_buttons[0] = 1'b0;
      repeat (l) @(posedge clk);
      #1;
      el = el + h + l;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("t3_bounce_busy", busy_cnt - b0, 0);
    chk("t3_bounce_result", o_result, 8'hFF);
    b0 = busy_cnt;
    press(3'b001, 8'h03, 200);
    chk("t3_long_busy", busy_cnt - b0, 1);
    chk("t3_long_result", o_result, 8'h02);

    // 4: shifts
    load3(8'h80, 8'h02, 8'h03);
    chk("t4_sra2", o_result, 8'hE0);
    press(3'b100, 8'h02, 20);
    chk("t4_srl2", o_result, 8'h20);
    press(3'b010, 8'h09, 20);
    chk("t4_srl9", o_result, 8'h00);
    chk("t4_srl9_zero", o_zero, 1'b1);
    press(3'b100, 8'h03, 20);
    chk("t4_sra9", o_result, 8'hFF);

    // 5: invalid op then AND
    press(3'b100, 8'h3F, 20);
    chk("t5_inv_result", o_result, 8'h00);
    chk("t5_inv_flag", o_invalid_op, 1'b1);
    chk("t5_inv_zero", o_zero, 1'b0);
    chk("t5_inv_valid", o_valid, 1'b1);
    load3(8'hF0, 8'h3C, 8'h24);
    chk("t5_and", o_result, 8'h30);
    chk("t5_and_inv", o_invalid_op, 1'b0);

    // 6: reset during evaluation with the OP button held through it
    @(posedge clk); #1;
    i_switches = 8'h26;
    repeat (4) @(posedge clk);
    #1;
    i_buttons[2] = 1'b1;
    e.edge_n = cyc + 7; e.mask = 3'b100; e.val = 8'h26;
    q.push_back(e);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("t6_in_exec", o_busy, 1'b1);
    #1;
    i_reset = 1'b1;
    #1;
    chk("t6_rst_result", o_result, 8'h00);
    chk("t6_rst_valid", o_valid, 1'b0);
    chk("t6_rst_busy", o_busy, 1'b0);
    chk("t6_rst_zero", o_zero, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    i_buttons[2] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("t6_held_no_load", o_valid, 1'b0);
    load3(8'h11, 8'h22, 8'h20);
    chk("t6_reload", o_result, 8'h33);
    chk("t6_reload_valid", o_valid, 1'b1);

    // Random reloads, including simultaneous presses
    for (int it = 0; it < 25; it++) begin
      which = $urandom_range(1, 7);
      hold = $urandom_range(6, 25);
      if (which[2] && ($urandom_range(0, 9) < 7)) v = ops[$urandom_range(0, 7)];
      else v = 8'($urandom_range(0, 255));
      press(3'(which), v, hold);
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
